alu_op_sequencer: RTL and testbench

//  Board-level controller for the combinational ALU (ports i_datoA/i_datoB/i_operation -> o_leds).
//  It loads operand A, operand B and the opcode from shared switches under three debounced push-buttons,

---
 rtl/alu_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer state encodings and the opcode legality check
// used by the ALU operand sequencer.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    S_WAIT_A = 3'd0,
    S_HAVE_A = 3'd1,
    S_HAVE_B = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability down-counter and a
// single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int N_DEBOUNCE = 16
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (N_DEBOUNCE > 1) ? $clog2(N_DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_DEBOUNCE - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synced input disagrees with the accepted level,
  // so a release must be as stable as a press before the level can fall.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync[1];
        r_pulse <= r_sync[1];
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads operand A, operand B and the opcode from shared switches under three
// debounced buttons, drives the external ALU and registers its result.
//
// state    | meaning
// S_WAIT_A | nothing loaded, waiting for load-A press
// S_HAVE_A | A loaded, waiting for load-B (or reload A)
// S_HAVE_B | A and B loaded, waiting for opcode/execute
// S_EXEC   | one cycle: capture ALU result
// S_DONE   | result valid, waiting for a new A
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ND_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int NB_SW      = 8,
  parameter int N_DEBOUNCE = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [2:0]         i_btn,
  input  logic [ND_DATA-1:0] i_alu_result,
  output logic [ND_DATA-1:0] o_datoA,
  output logic [ND_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic [ND_DATA-1:0] o_leds,
  output logic               o_valid,
  output logic               o_err,
  output logic [2:0]         o_state
);

  logic [2:0]         w_pulse;
  logic [NB_OP-1:0]   w_sw_op;
  logic               w_op_legal;
  state_t             r_state;
  state_t             w_next;
  logic               w_ld_a;
  logic               w_ld_b;
  logic               w_ld_op;
  logic               w_set_err;
  logic               w_exec;

  logic [ND_DATA-1:0] r_dato_a;
  logic [ND_DATA-1:0] r_dato_b;
  logic [NB_OP-1:0]   r_op;
  logic [ND_DATA-1:0] r_leds;
  logic               r_valid;
  logic               r_err;

  for (genvar g = 0; g < 3; g++) begin : g_db
    btn_debounce #(.N_DEBOUNCE(N_DEBOUNCE)) u_db (
      .clk    (clk),
      .i_rst  (i_rst),
      .i_btn  (i_btn[g]),
      .o_pulse(w_pulse[g])
    );
  end

  assign w_sw_op    = i_sw[NB_OP-1:0];
  assign w_op_legal = is_legal_op(w_sw_op);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= S_WAIT_A;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_A: if (w_pulse[0]) w_next = S_HAVE_A;
      S_HAVE_A: if (w_pulse[1]) w_next = S_HAVE_B;
      S_HAVE_B: begin
        if (w_pulse[2]) begin
          if (w_op_legal) w_next = S_EXEC;
        end else if (!w_pulse[1] && w_pulse[0]) begin
          w_next = S_HAVE_A;
        end
      end
      S_EXEC:   w_next = S_DONE;
      S_DONE:   if (w_pulse[0]) w_next = S_HAVE_A;
      default:  w_next = S_WAIT_A;
    endcase
  end

  // Priority inside each state keeps exactly one action per cycle.
  always_comb begin
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_op   = 1'b0;
    w_set_err = 1'b0;
    w_exec    = 1'b0;
    case (r_state)
      S_WAIT_A: w_ld_a = w_pulse[0];
      S_HAVE_A: begin
        w_ld_b = w_pulse[1];
        w_ld_a = !w_pulse[1] && w_pulse[0];
      end
      S_HAVE_B: begin
        if (w_pulse[2]) begin
          w_ld_op   = w_op_legal;
          w_set_err = !w_op_legal;
        end else if (w_pulse[1]) begin
          w_ld_b = 1'b1;
        end else begin
          w_ld_a = w_pulse[0];
        end
      end
      S_EXEC:   w_exec = 1'b1;
      S_DONE:   w_ld_a = w_pulse[0];
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_op     <= '0;
      r_leds   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_ld_a)  r_dato_a <= i_sw[ND_DATA-1:0];
      if (w_ld_b)  r_dato_b <= i_sw[ND_DATA-1:0];
      if (w_ld_op) r_op     <= w_sw_op;
      if (w_exec)  r_leds   <= i_alu_result;

      if (w_set_err)                         r_err <= 1'b1;
      else if (w_ld_a || w_ld_b || w_ld_op)  r_err <= 1'b0;

      if (w_exec)                r_valid <= 1'b1;
      else if (w_ld_a || w_ld_b) r_valid <= 1'b0;
    end
  end

  assign o_datoA     = r_dato_a;
  assign o_datoB     = r_dato_b;
  assign o_operation = r_op;
  assign o_leds      = r_leds;
  assign o_valid     = r_valid;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU closing the loop.
module tb_alu_op_sequencer;

  localparam int ND = 4;
  localparam logic [2:0] ST_WAIT_A = 3'd0, ST_HAVE_A = 3'd1, ST_HAVE_B = 3'd2,
                         ST_EXEC = 3'd3, ST_DONE = 3'd4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [7:0]    i_sw = '0;
  logic [2:0]    i_btn = '0;
  logic [ND-1:0] i_alu_result;
  logic [ND-1:0] o_datoA, o_datoB, o_leds;
  logic [5:0]    o_operation;
  logic          o_valid, o_err;
  logic [2:0]    o_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [ND-1:0] alu_model(input logic [ND-1:0] a, input logic [ND-1:0] b,
                                              input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000010: return a >> b;
      6'b000011: return ND'($signed(a) >>> b);
      default:   return '0;
    endcase
  endfunction

  assign i_alu_result = alu_model(o_datoA, o_datoB, o_operation);

  alu_op_sequencer #(.ND_DATA(ND), .NB_OP(6), .NB_SW(8), .N_DEBOUNCE(4)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_sw        (i_sw),
    .i_btn       (i_btn),
    .i_alu_result(i_alu_result),
    .o_datoA     (o_datoA),
    .o_datoB     (o_datoB),
    .o_operation (o_operation),
    .o_leds      (o_leds),
    .o_valid     (o_valid),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  task automatic apply_reset();
    @(negedge clk); i_rst = 1'b1; i_btn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); i_rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Holds the buttons long enough for one accepted press, then a clean release.
  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    @(negedge clk); i_sw = sw; i_btn = mask;
    repeat (10) @(posedge clk);
    @(negedge clk); i_btn = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_btns();
    @(negedge clk); i_btn = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (o_state !== ST_WAIT_A) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_WAIT_A); end
    n_vec++; if ({o_datoA, o_datoB, o_leds} !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h expected 000", {o_datoA, o_datoB, o_leds}); end
    n_vec++; if ({o_operation, o_valid, o_err} !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %b expected 00000000", {o_operation, o_valid, o_err}); end
  endtask

  task automatic test_basic_add();
    press(3'b001, 8'b0011);
    n_vec++; if (o_state !== ST_HAVE_A || o_datoA !== 4'b0011) begin n_err++; $display("FAIL add_load_a: got st=%0d a=%b expected st=1 a=0011", o_state, o_datoA); end
    press(3'b010, 8'b0101);
    n_vec++; if (o_state !== ST_HAVE_B || o_datoB !== 4'b0101) begin n_err++; $display("FAIL add_load_b: got st=%0d b=%b expected st=2 b=0101", o_state, o_datoB); end
    @(negedge clk); i_sw = 8'b00100000; i_btn = 3'b100;
    repeat (6) @(posedge clk); #1;
    n_vec++; if (o_state !== ST_HAVE_B || o_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse_cycle: got st=%0d v=%b expected st=2 v=0", o_state, o_valid); end
    @(posedge clk); #1;
    n_vec++; if (o_state !== ST_EXEC || o_valid !== 1'b0) begin n_err++; $display("FAIL add_exec_cycle: got st=%0d v=%b expected st=3 v=0", o_state, o_valid); end
    @(posedge clk); #1;
    n_vec++; if (o_valid !== 1'b1 || o_leds !== 4'b1000 || o_err !== 1'b0 || o_state !== ST_DONE) begin n_err++; $display("FAIL add_result: got v=%b leds=%b err=%b st=%0d expected v=1 leds=1000 err=0 st=4", o_valid, o_leds, o_err, o_state); end
    release_btns();
  endtask

  task automatic test_sra_and_done();
    press(3'b001, 8'b1100);
    n_vec++; if (o_valid !== 1'b0 || o_state !== ST_HAVE_A) begin n_err++; $display("FAIL done_reload_a: got v=%b st=%0d expected v=0 st=1", o_valid, o_state); end
    press(3'b010, 8'b0010);
    press(3'b100, 8'b00000011);
    n_vec++; if (o_leds !== 4'b1111 || o_valid !== 1'b1 || o_operation !== 6'b000011) begin n_err++; $display("FAIL sra_result: got leds=%b v=%b op=%b expected leds=1111 v=1 op=000011", o_leds, o_valid, o_operation); end
    @(negedge clk); i_sw = 8'b0001; i_btn = 3'b001;
    repeat (6) @(posedge clk); #1;
    n_vec++; if (o_valid !== 1'b1 || o_state !== ST_DONE) begin n_err++; $display("FAIL done_before_p0: got v=%b st=%0d expected v=1 st=4", o_valid, o_state); end
    @(posedge clk); #1;
    n_vec++; if (o_valid !== 1'b0 || o_state !== ST_HAVE_A || o_datoA !== 4'b0001 || o_leds !== 4'b1111) begin n_err++; $display("FAIL done_p0: got v=%b st=%0d a=%b leds=%b expected v=0 st=1 a=0001 leds=1111", o_valid, o_state, o_datoA, o_leds); end
    release_btns();
  endtask

  task automatic test_illegal_op();
    press(3'b010, 8'b0010);
    press(3'b100, 8'b00111111);
    n_vec++; if (o_err !== 1'b1 || o_state !== ST_HAVE_B || o_operation !== 6'b000011) begin n_err++; $display("FAIL illegal_op: got err=%b st=%0d op=%b expected err=1 st=2 op=000011", o_err, o_state, o_operation); end
    press(3'b100, 8'b00100111);
    n_vec++; if (o_leds !== 4'b1100 || o_err !== 1'b0 || o_valid !== 1'b1 || o_operation !== 6'b100111) begin n_err++; $display("FAIL nor_result: got leds=%b err=%b v=%b op=%b expected leds=1100 err=0 v=1 op=100111", o_leds, o_err, o_valid, o_operation); end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    press(3'b010, 8'b0111);
    n_vec++; if (o_state !== ST_WAIT_A || o_datoB !== 4'b0000) begin n_err++; $display("FAIL ooo_p1: got st=%0d b=%b expected st=0 b=0000", o_state, o_datoB); end
    press(3'b100, 8'b00100000);
    n_vec++; if (o_state !== ST_WAIT_A || o_operation !== 6'b000000) begin n_err++; $display("FAIL ooo_p2: got st=%0d op=%b expected st=0 op=000000", o_state, o_operation); end
    press(3'b001, 8'b0100);
    press(3'b011, 8'b1001);
    n_vec++; if (o_state !== ST_HAVE_B || o_datoB !== 4'b1001 || o_datoA !== 4'b0100) begin n_err++; $display("FAIL simul_p0_p1: got st=%0d a=%b b=%b expected st=2 a=0100 b=1001", o_state, o_datoA, o_datoB); end
    press(3'b100, 8'b00100101);
    n_vec++; if (o_leds !== 4'b1101 || o_valid !== 1'b1) begin n_err++; $display("FAIL or_result: got leds=%b v=%b expected leds=1101 v=1", o_leds, o_valid); end
    press(3'b001, 8'b1010);
    press(3'b010, 8'b0011);
    n_vec++; if (o_state !== ST_HAVE_B || o_valid !== 1'b0) begin n_err++; $display("FAIL ooo_reload: got st=%0d v=%b expected st=2 v=0", o_state, o_valid); end
  endtask

  task automatic test_reset_mid();
    press(3'b100, 8'b00111111);
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL mid_err_set: got %b expected 1", o_err); end
    @(negedge clk); i_sw = 8'b1010; i_btn = 3'b001;
    repeat (2) @(posedge clk);
    @(negedge clk); i_rst = 1'b1; #1;
    n_vec++; if (o_state !== ST_WAIT_A || {o_datoA, o_datoB, o_leds} !== 12'h000 || {o_operation, o_valid, o_err} !== 8'h00) begin n_err++; $display("FAIL mid_reset_outputs: got st=%0d data=%h ctrl=%b expected st=0 data=000 ctrl=00000000", o_state, {o_datoA, o_datoB, o_leds}, {o_operation, o_valid, o_err}); end
    @(negedge clk); i_rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_vec++; if (o_state !== ST_WAIT_A || o_datoA !== 4'b0000) begin n_err++; $display("FAIL mid_no_spurious: got st=%0d a=%b expected st=0 a=0000", o_state, o_datoA); end
    repeat (6) @(posedge clk); #1;
    n_vec++; if (o_state !== ST_HAVE_A || o_datoA !== 4'b1010) begin n_err++; $display("FAIL mid_held_load: got st=%0d a=%b expected st=1 a=1010", o_state, o_datoA); end
    release_btns();
  endtask

  task automatic test_bounce();
    apply_reset();
    i_sw = 8'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); i_btn = 3'b001;
      @(negedge clk);
      @(negedge clk); i_btn = 3'b000;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_vec++; if (o_state !== ST_WAIT_A || o_datoA !== 4'b0000) begin n_err++; $display("FAIL bounce_rejected: got st=%0d a=%b expected st=0 a=0000", o_state, o_datoA); end
    @(negedge clk); i_btn = 3'b001;
    repeat (10) @(posedge clk); #1;
    n_vec++; if (o_state !== ST_HAVE_A || o_datoA !== 4'b0110) begin n_err++; $display("FAIL bounce_stable_load: got st=%0d a=%b expected st=1 a=0110", o_state, o_datoA); end
    @(negedge clk); i_sw = 8'b1001;
    repeat (30) @(posedge clk); #1;
    n_vec++; if (o_state !== ST_HAVE_A || o_datoA !== 4'b0110) begin n_err++; $display("FAIL held_no_repeat: got st=%0d a=%b expected st=1 a=0110", o_state, o_datoA); end
    release_btns();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_sra_and_done();
    test_illegal_op();
    test_out_of_order();
    test_reset_mid();
    test_bounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
